// File: rtl/packet_recovery_param.sv
// Serial frame recovery: hunts for a sync word, reads a length field, streams the
// payload out bit by bit and checks the trailing CRC, keeping saturating frame/error counts.
module packet_recovery_param #(
    parameter int                  SYNC_LEN     = 32,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 32'h1ACFFC1D,
    parameter int                  MAX_SYNC_ERR = 0,
    parameter int                  LEN_W        = 8,
    parameter int                  MAX_LEN      = 255,
    parameter int                  CRC_W        = 16,
    parameter logic [CRC_W-1:0]    CRC_POLY     = 16'h1021,
    parameter logic [CRC_W-1:0]    CRC_INIT     = 16'hFFFF,
    parameter int                  CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             valid_in,
    output logic             bit_out,
    output logic             valid_out,
    output logic             frame_done,
    output logic             crc_valid,
    output logic             crc_error,
    output logic             len_error,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count
);

    localparam int PAY_W   = $clog2(MAX_LEN * 8 + 1);
    localparam int CMP_W   = LEN_W + 3;
    localparam int FLD_MAX = (LEN_W > CRC_W) ? LEN_W : CRC_W;
    localparam int FLD_W   = $clog2(FLD_MAX + 1);
    localparam int ERR_W   = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {HUNT, LENGTH, PAYLOAD, CHECK} state_t;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    state_t             state;
    // The oldest sync bit would fall off on the very shift that could use it, so only SYNC_LEN-1 are kept.
    logic [SYNC_LEN-2:0] sync_sr;
    logic [LEN_W-1:0]   len_reg;
    logic [CRC_W-1:0]   crc;
    logic [CRC_W-2:0]   rx_crc;
    logic [PAY_W-1:0]   pay_cnt;
    logic [FLD_W-1:0]   fld_cnt;

    logic [SYNC_LEN-1:0] sync_cand;
    logic [ERR_W-1:0]    sync_dist;
    logic                sync_hit;
    logic [LEN_W-1:0]    len_next;
    logic                len_over;
    logic [CRC_W-1:0]    rx_next;
    logic [CRC_W-1:0]    crc_upd;
    logic                pay_last;

    assign sync_cand = {sync_sr, bit_in};
    assign sync_hit  = (sync_dist <= ERR_W'(MAX_SYNC_ERR));
    assign len_next  = {len_reg[LEN_W-2:0], bit_in};
    assign len_over  = ({1'b0, len_next} > (LEN_W + 1)'(MAX_LEN));
    assign rx_next   = {rx_crc, bit_in};
    assign crc_upd   = crc_step(crc, bit_in);
    assign pay_last  = (CMP_W'(pay_cnt) == ({len_reg, 3'b000} - CMP_W'(1)));

    always_comb begin
        sync_dist = '0;
        for (int i = 0; i < SYNC_LEN; i++)
            sync_dist = sync_dist + ERR_W'(sync_cand[i] ^ SYNC_WORD[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            sync_sr     <= '0;
            len_reg     <= '0;
            crc         <= CRC_INIT;
            rx_crc      <= '0;
            pay_cnt     <= '0;
            fld_cnt     <= '0;
            bit_out     <= 1'b0;
            valid_out   <= 1'b0;
            frame_done  <= 1'b0;
            crc_valid   <= 1'b0;
            crc_error   <= 1'b0;
            len_error   <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
        end else begin
            // NOTE: pulses default low every edge and only the event branch raises them,
            // so each is registered and lasts exactly one cycle.
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            crc_valid  <= 1'b0;
            crc_error  <= 1'b0;
            len_error  <= 1'b0;
            if (valid_in) begin
                case (state)
                    HUNT: begin
                        if (sync_hit) begin
                            state   <= LENGTH;
                            sync_sr <= '0;
                            crc     <= CRC_INIT;
                            fld_cnt <= '0;
                        end else begin
                            sync_sr <= sync_cand[SYNC_LEN-2:0];
                        end
                    end
                    LENGTH: begin
                        len_reg <= len_next;
                        crc     <= crc_upd;
                        fld_cnt <= fld_cnt + FLD_W'(1);
                        if (fld_cnt == FLD_W'(LEN_W - 1)) begin
                            fld_cnt <= '0;
                            pay_cnt <= '0;
                            if (len_over) begin
                                state     <= HUNT;
                                len_error <= 1'b1;
                                if (error_count != '1) error_count <= error_count + CNT_W'(1);
                            end else if (len_next == '0) begin
                                state <= CHECK;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        bit_out   <= bit_in;
                        valid_out <= 1'b1;
                        crc       <= crc_upd;
                        pay_cnt   <= pay_cnt + PAY_W'(1);
                        if (pay_last) begin
                            state   <= CHECK;
                            fld_cnt <= '0;
                        end
                    end
                    CHECK: begin
                        rx_crc  <= rx_next[CRC_W-2:0];
                        fld_cnt <= fld_cnt + FLD_W'(1);
                        if (fld_cnt == FLD_W'(CRC_W - 1)) begin
                            state      <= HUNT;
                            sync_sr    <= '0;
                            frame_done <= 1'b1;
                            if (rx_next == crc) begin
                                crc_valid <= 1'b1;
                                if (frame_count != '1) frame_count <= frame_count + CNT_W'(1);
                            end else begin
                                crc_error <= 1'b1;
                                if (error_count != '1) error_count <= error_count + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_recovery_param.sv
// Frame-level reference bench: frames are built from fields, each consumed bit carries the
// event it must cause one cycle later, and a single process compares both DUTs every cycle.
module tb_packet_recovery_param;

    typedef enum {A_NONE, A_PAY, A_OK, A_BAD, A_LEN} ann_t;
    typedef struct {logic b; ann_t a;} item_t;
    typedef struct packed {logic vo, bo, fd, cv, ce, le;} out_t;

    localparam logic [31:0] SW = 32'h1ACFFC1D;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic va = 1'b0, ba = 1'b0, vb = 1'b0, bb = 1'b0;
    logic bo_a, vo_a, fd_a, cv_a, ce_a, le_a;
    logic bo_b, vo_b, fd_b, cv_b, ce_b, le_b;
    logic [15:0] fc_a, ec_a;
    logic [1:0]  fc_b, ec_b;

    packet_recovery_param dut_a (
        .clk(clk), .rst(rst), .bit_in(ba), .valid_in(va),
        .bit_out(bo_a), .valid_out(vo_a), .frame_done(fd_a), .crc_valid(cv_a),
        .crc_error(ce_a), .len_error(le_a), .frame_count(fc_a), .error_count(ec_a)
    );

    packet_recovery_param #(.MAX_SYNC_ERR(2), .MAX_LEN(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bb), .valid_in(vb),
        .bit_out(bo_b), .valid_out(vo_b), .frame_done(fd_b), .crc_valid(cv_b),
        .crc_error(ce_b), .len_error(le_b), .frame_count(fc_b), .error_count(ec_b)
    );

    out_t exp_a = '0, exp_b = '0;
    int   mfc_a = 0, mec_a = 0, mfc_b = 0, mec_b = 0;
    int   n_pass = 0, n_total = 0;
    item_t frame_q[$];
    logic  obs_a[$];
    bit    rec_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // CRC-16 over length byte then payload bytes, MSB first, seed FFFF, no final XOR.
    function automatic logic [15:0] model_crc(input logic [7:0] len, input logic [7:0] pay[$]);
        logic [15:0] c;
        logic [7:0]  bv;
        logic        fb;
        c = 16'hFFFF;
        for (int k = -1; k < pay.size(); k++) begin
            bv = (k < 0) ? len : pay[k];
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ bv[i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic build(input logic [31:0] sw, input bit lock, input logic [7:0] len,
                         input logic [7:0] pay[$], input logic [15:0] xmask, input int max_len);
        logic [15:0] c;
        frame_q.delete();
        for (int i = 31; i >= 0; i--) frame_q.push_back('{sw[i], A_NONE});
        if (!lock) begin
            repeat (24) frame_q.push_back('{1'b0, A_NONE});
            return;
        end
        for (int i = 7; i >= 0; i--)
            frame_q.push_back('{len[i], (i == 0 && int'(len) > max_len) ? A_LEN : A_NONE});
        if (int'(len) > max_len) return;
        foreach (pay[k])
            for (int i = 7; i >= 0; i--) frame_q.push_back('{pay[k][i], A_PAY});
        c = model_crc(len, pay) ^ xmask;
        for (int i = 15; i >= 0; i--)
            frame_q.push_back('{c[i], (i != 0) ? A_NONE : ((xmask == 16'h0) ? A_OK : A_BAD)});
    endtask

    task automatic apply(input bit v, input logic b, input ann_t a, input int cmax,
                         output out_t e, inout int fc, inout int ec);
        e = '0;
        if (v) begin
            case (a)
                A_PAY: begin e.vo = 1'b1; e.bo = b; end
                A_OK:  begin e.fd = 1'b1; e.cv = 1'b1; if (fc < cmax) fc++; end
                A_BAD: begin e.fd = 1'b1; e.ce = 1'b1; if (ec < cmax) ec++; end
                A_LEN: begin e.le = 1'b1; if (ec < cmax) ec++; end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input int sel, input bit v, input logic b, input ann_t a);
        if (sel == 0) begin va = v; ba = b; vb = 1'b0; bb = 1'($urandom); end
        else          begin vb = v; bb = b; va = 1'b0; ba = 1'($urandom); end
        @(posedge clk);
        apply((sel == 0) && v, b, a, 65535, exp_a, mfc_a, mec_a);
        apply((sel == 1) && v, b, a, 3,     exp_b, mfc_b, mec_b);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 1'b0, 1'($urandom), A_NONE);
    endtask

    task automatic send(input int sel, input bit gaps, input int n);
        for (int i = 0; i < n && i < frame_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) cycle(sel, 1'b0, 1'($urandom), A_NONE);
            cycle(sel, 1'b1, frame_q[i].b, frame_q[i].a);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_a = '0; exp_b = '0;
        mfc_a = 0; mec_a = 0; mfc_b = 0; mec_b = 0;
        idle(3);
        rst = 1'b1;
    endtask

    // Outputs are sampled on the falling edge, half a cycle clear of the consuming edge.
    initial forever begin
        @(negedge clk);
        check("outs_a", {vo_a, vo_a & bo_a, fd_a, cv_a, ce_a, le_a}, exp_a);
        check("outs_b", {vo_b, vo_b & bo_b, fd_b, cv_b, ce_b, le_b}, exp_b);
        check("frame_count_a", fc_a, mfc_a);
        check("error_count_a", ec_a, mec_a);
        check("frame_count_b", fc_b, mfc_b);
        check("error_count_b", ec_b, mec_b);
        if (rec_a && vo_a) obs_a.push_back(bo_a);
    end

    initial begin
        logic [7:0]  none_q[$];
        logic [7:0]  pay_q[$];
        logic [15:0] got;
        logic [31:0] m;
        int          len;

        #1 rst = 1'b0;
        idle(3);
        rst = 1'b1;

        pay_q = {8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_empty", model_crc(8'h00, none_q), 16'hE1F0);
        check("model_crc_123456789", model_crc(8'h31, pay_q), 16'h29B1);

        idle(100);
        check("idle_frame_count", fc_a, 32'd0);

        build(SW, 1'b1, 8'h00, none_q, 16'h0000, 255);
        send(0, 1'b0, frame_q.size());
        idle(3);
        check("empty_frame_count", fc_a, 32'd1);

        build(SW, 1'b1, 8'h00, none_q, 16'h0001, 255);
        send(0, 1'b0, frame_q.size());
        idle(3);
        check("bad_crc_error_count", ec_a, 32'd1);
        check("bad_crc_frame_count", fc_a, 32'd1);

        pay_q = {8'hA5, 8'h5A};
        build(SW, 1'b1, 8'h02, pay_q, 16'h0000, 255);
        obs_a.delete();
        rec_a = 1'b1;
        send(0, 1'b1, frame_q.size());
        idle(3);
        rec_a = 1'b0;
        got = '0;
        foreach (obs_a[i]) got = {got[14:0], obs_a[i]};
        check("payload_bit_count", obs_a.size(), 32'd16);
        check("payload_bits", got, 16'b1010010101011010);
        check("payload_frame_count", fc_a, 32'd2);

        build(SW, 1'b1, 8'h05, none_q, 16'h0000, 4);
        send(1, 1'b0, frame_q.size());
        idle(3);
        check("len_error_count", ec_b, 32'd1);
        pay_q = {8'h11, 8'hC3, 8'h7E};
        build(SW, 1'b1, 8'h03, pay_q, 16'h0000, 4);
        send(1, 1'b1, frame_q.size());
        idle(3);
        check("after_len_error_frame_count", fc_b, 32'd1);

        pay_q = {8'h96};
        build(SW ^ 32'h0010_0008, 1'b1, 8'h01, pay_q, 16'h0000, 4);
        send(1, 1'b0, frame_q.size());
        idle(3);
        check("two_flip_lock_count", fc_b, 32'd2);
        build(SW ^ 32'h4000_8001, 1'b0, 8'h01, pay_q, 16'h0000, 4);
        send(1, 1'b0, frame_q.size());
        idle(3);
        check("three_flip_no_lock_count", fc_b, 32'd2);

        repeat (4) begin
            build(SW, 1'b1, 8'hFF, none_q, 16'h0000, 4);
            send(1, 1'b1, frame_q.size());
            idle(2);
        end
        check("error_count_saturated", ec_b, 32'd3);

        pay_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(SW, 1'b1, 8'h04, pay_q, 16'h0000, 4);
        send(1, 1'b0, 50);
        do_reset();
        idle(20);
        check("reset_mid_frame_count", fc_b, 32'd0);
        pay_q = {8'h5C};
        build(SW, 1'b1, 8'h01, pay_q, 16'h0000, 4);
        send(1, 1'b0, frame_q.size());
        idle(3);
        check("resume_after_reset_count", fc_b, 32'd1);

        for (int f = 0; f < 24; f++) begin
            int sel;
            sel = $urandom_range(0, 1);
            len = $urandom_range(0, 6);
            pay_q.delete();
            repeat (len) pay_q.push_back(8'($urandom));
            if (sel == 0) begin
                build(SW, 1'b1, 8'(len), pay_q,
                      ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0, 255);
            end else begin
                m = '0;
                repeat ($urandom_range(0, 2)) m[$urandom_range(0, 31)] = 1'b1;
                build(SW ^ m, 1'b1, 8'(len), pay_q, 16'h0000, 4);
            end
            send(sel, $urandom_range(0, 1) == 1, frame_q.size());
            idle($urandom_range(1, 5));
        end

        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
